bundle_packer: RTL

//  Packs independent slot-A (ALU) and slot-B (load/store/jump/branch) 16-bit micro-ops into 32-bit

---
 rtl/bundle_pkg.sv | 30 +++
 rtl/bundle_packer_if.sv | 24 ++
 rtl/bundle_packer_slot_fifo.sv | 57 +++++
 rtl/bundle_packer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bundle_pkg.sv
// Shared opcodes, slot width, NOP word, FSM encoding and opcode screening helpers for the bundle packer.
package bundle_pkg;

  localparam int unsigned SLOT_W = 16;
  localparam int unsigned OP_W   = 5;

  localparam logic [OP_W-1:0] OP_ALU_R = 5'b01000;
  localparam logic [OP_W-1:0] OP_ALU_I = 5'b00101;
  localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LD    = 5'b01010;
  localparam logic [OP_W-1:0] OP_ST    = 5'b01011;
  localparam logic [OP_W-1:0] OP_JMP   = 5'b11110;
  localparam logic [OP_W-1:0] OP_BR    = 5'b11011;

  localparam logic [SLOT_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PART = 1'b1
  } state_e;

  function automatic logic legal_a(input logic [OP_W-1:0] op);
    return (op == OP_ALU_R) || (op == OP_ALU_I) || (op == OP_NOP);
  endfunction

  function automatic logic legal_b(input logic [OP_W-1:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_JMP) || (op == OP_BR) || (op == OP_NOP);
  endfunction

endpackage

// File: rtl/bundle_packer_if.sv
// Slot-A / slot-B micro-op inputs and the IR bundle output of the bundle packer.
interface bundle_packer_if;
  import bundle_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [SLOT_W-1:0] a_word;
  logic              b_valid;
  logic              b_ready;
  logic [SLOT_W-1:0] b_word;
  logic              ir_valid;
  logic              ir_ready;
  logic [31:0]       ir;

  modport master (
    output a_valid, a_word, b_valid, b_word, ir_ready,
    input  a_ready, b_ready, ir_valid, ir
  );

  modport slave (
    input  a_valid, a_word, b_valid, b_word, ir_ready,
    output a_ready, b_ready, ir_valid, ir
  );
endinterface

// File: rtl/bundle_packer_slot_fifo.sv
// slot_fifo: synchronous FIFO for one issue slot; push ignored when full, pop ignored when empty.
module slot_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/bundle_packer.sv
// Packs slot-A/slot-B micro-ops into 32-bit dual-issue IR words, NOP-padding a lone head after a wait.
// Optional BUNDLE_PACKER_STATS_EN adds accepted-bundle and padded-bundle counters.
module bundle_packer
  import bundle_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  bundle_packer_if.slave     bus,
  output logic               illegal_op
`ifdef BUNDLE_PACKER_STATS_EN
  ,
  output logic [15:0]        stat_bundles,
  output logic [15:0]        stat_pads
`endif
);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              ir_valid_q, ir_valid_d;
  logic [31:0]       ir_q, ir_d;
  logic              pad_q, pad_d;
  logic              illegal_q, illegal_d;

  logic              a_push, b_push, a_pop, b_pop, a_full, b_full, a_empty, b_empty;
  logic [SLOT_W-1:0] a_store, b_store, a_head, b_head;
  logic              a_h, b_h, b_jump, can_load, issue, pad;
  logic [31:0]       bundle, lone_bundle;

  // Illegal opcodes are replaced by NOP before they enter the FIFO
  assign a_store = legal_a(bus.a_word[OP_W-1:0]) ? bus.a_word : NOP_WORD;
  assign b_store = legal_b(bus.b_word[OP_W-1:0]) ? bus.b_word : NOP_WORD;
  assign a_push  = bus.a_valid && !a_full;
  assign b_push  = bus.b_valid && !b_full;

  slot_fifo #(.DEPTH(DEPTH), .WIDTH(SLOT_W)) u_fifo_a (
    .clk(clk), .reset(reset), .push(a_push), .pop(a_pop), .din(a_store),
    .head(a_head), .full(a_full), .empty(a_empty)
  );

  slot_fifo #(.DEPTH(DEPTH), .WIDTH(SLOT_W)) u_fifo_b (
    .clk(clk), .reset(reset), .push(b_push), .pop(b_pop), .din(b_store),
    .head(b_head), .full(b_full), .empty(b_empty)
  );

  assign a_h         = !a_empty;
  assign b_h         = !b_empty;
  assign b_jump      = (b_head[OP_W-1:0] == OP_JMP) || (b_head[OP_W-1:0] == OP_BR);
  assign can_load    = !ir_valid_q || bus.ir_ready;
  assign lone_bundle = a_h ? {NOP_WORD, a_head} : {b_head, NOP_WORD};

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    issue   = 1'b0;
    pad     = 1'b0;
    a_pop   = 1'b0;
    b_pop   = 1'b0;
    bundle  = {NOP_WORD, NOP_WORD};
    case (state_q)
      ST_IDLE: begin
        if (a_h && b_h) begin
          issue = can_load;
          bundle = {b_head, a_head};
        end else if (b_h && b_jump) begin
          issue = can_load;
          pad   = 1'b1;
          bundle = lone_bundle;
        end else if (a_h || b_h) begin
          if (WAIT_CYCLES == 0) begin
            issue = can_load;
            pad   = 1'b1;
            bundle = lone_bundle;
          end else begin
            state_d = ST_PART;
            wait_d  = '0;
          end
        end
      end
      ST_PART: begin
        if (a_h && b_h) begin
          issue  = can_load;
          bundle = {b_head, a_head};
          if (can_load) state_d = ST_IDLE;
        end else if (!a_h && !b_h) begin
          state_d = ST_IDLE;
        end else if (wait_q == LAST) begin
          // Busy output register: hold here with wait_cnt saturated
          issue  = can_load;
          pad    = 1'b1;
          bundle = lone_bundle;
          if (can_load) state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      a_pop = a_h && (bundle[SLOT_W-1:0] == a_head) && !(pad && !a_h);
      a_pop = a_h && !(pad && b_h);
      b_pop = b_h && !(pad && a_h);
    end
  end

  always_comb begin
    ir_valid_d = ir_valid_q && !bus.ir_ready;
    ir_d       = ir_q;
    pad_d      = pad_q;
    illegal_d  = illegal_q
               || (a_push && !legal_a(bus.a_word[OP_W-1:0]))
               || (b_push && !legal_b(bus.b_word[OP_W-1:0]));
    if (issue) begin
      ir_valid_d = 1'b1;
      ir_d       = bundle;
      pad_d      = pad;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      ir_valid_q <= 1'b0;
      ir_q       <= '0;
      pad_q      <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      ir_valid_q <= ir_valid_d;
      ir_q       <= ir_d;
      pad_q      <= pad_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.a_ready  = !a_full;
  assign bus.b_ready  = !b_full;
  assign bus.ir_valid = ir_valid_q;
  assign bus.ir       = ir_q;
  assign illegal_op   = illegal_q;

`ifdef BUNDLE_PACKER_STATS_EN
  logic [15:0] bundles_q, bundles_d, pads_q, pads_d;
  logic        accept;

  assign accept = ir_valid_q && bus.ir_ready;

  always_comb begin
    bundles_d = bundles_q;
    pads_d    = pads_q;
    if (accept) begin
      bundles_d = bundles_q + 16'(1);
      if (pad_q) pads_d = pads_q + 16'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bundles_q <= '0;
      pads_q    <= '0;
    end else begin
      bundles_q <= bundles_d;
      pads_q    <= pads_d;
    end
  end

  assign stat_bundles = bundles_q;
  assign stat_pads    = pads_q;
`endif
endmodule
